exibe_sequencia: RTL and testbench

EXIBE_SEQUENCIA -- requirements
Module: exibe_sequencia

---
 rtl/exibe_sequencia.sv | 160 ++++++++++++++++
 tb/tb_exibe_sequencia.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/exibe_sequencia.sv
// exibe_sequencia -- plays back a stored sequence of 4-bit items on the LEDs.
//
// After a start request, the block walks the sequence memory from address 0
// up to the index latched from `limite`. Each item is shown for T_ON cycles
// and followed by T_OFF dark cycles. When the last item's dark gap ends, a
// single-cycle `fim` pulse is raised and the block returns to idle.
//
// Optional feature: define EXIBE_PISCA_FINAL_EN to add a final flash
// (all LEDs on for T_ON cycles) between the last dark gap and `fim`.
//
// Ports:
//   clock      - single clock, all state on the rising edge
//   reset      - asynchronous, active-low reset
//   iniciar    - start request, only honoured while idle
//   abortar    - synchronous abort, overrides every other input
//   limite     - index of the last item of the round (latched at start)
//   dado       - item read combinationally from sequence memory at `endereco`
//   endereco   - registered sequence memory read address
//   leds       - display drive (dado while lit, 4'b1111 during final flash)
//   ocupado    - high whenever the block is not idle
//   fim        - one-cycle end-of-sequence pulse
//   db_estado  - current state code (4'b1001 for an illegal state)
module exibe_sequencia #(
    parameter int unsigned T_ON  = 4,
    parameter int unsigned T_OFF = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       abortar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       fim,
    output logic [3:0] db_estado
);

    localparam int unsigned T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACENDE  = 3'd2,
        APAGA   = 3'd3,
        PROXIMO = 3'd4,
        PISCA   = 3'd5,
        FIM     = 3'd6
    } estado_t;

    estado_t         estado, estado_prox;
    logic [3:0]      endereco_prox;
    logic [3:0]      limite_reg, limite_prox;
    logic [TW-1:0]   timer, timer_prox;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= OCIOSO;
            endereco   <= '0;
            limite_reg <= '0;
            timer      <= '0;
        end else begin
            estado     <= estado_prox;
            endereco   <= endereco_prox;
            limite_reg <= limite_prox;
            timer      <= timer_prox;
        end
    end

    always_comb begin
        estado_prox   = estado;
        endereco_prox = endereco;
        limite_prox   = limite_reg;
        timer_prox    = timer;
        leds          = '0;
        ocupado       = 1'b1;
        fim           = 1'b0;
        db_estado     = {1'b0, estado};

        case (estado)
            OCIOSO: begin
                ocupado = 1'b0;
                if (iniciar) begin
                    estado_prox   = CARREGA;
                    endereco_prox = '0;
                    limite_prox   = limite;
                    timer_prox    = '0;
                end
            end
            CARREGA: begin
                estado_prox = ACENDE;
                timer_prox  = '0;
            end
            ACENDE: begin
                leds = dado;
                if (timer == TW'(T_ON - 1)) begin
                    estado_prox = APAGA;
                    timer_prox  = '0;
                end else begin
                    timer_prox = timer + TW'(1);
                end
            end
            APAGA: begin
                if (timer == TW'(T_OFF - 1)) begin
                    timer_prox = '0;
                    if (endereco == limite_reg) begin
`ifdef EXIBE_PISCA_FINAL_EN
                        estado_prox = PISCA;
`else
                        estado_prox = FIM;
`endif
                    end else begin
                        estado_prox = PROXIMO;
                    end
                end else begin
                    timer_prox = timer + TW'(1);
                end
            end
            PROXIMO: begin
                endereco_prox = endereco + 4'd1;
                estado_prox   = ACENDE;
                timer_prox    = '0;
            end
`ifdef EXIBE_PISCA_FINAL_EN
            PISCA: begin
                leds = '1;
                if (timer == TW'(T_ON - 1)) begin
                    estado_prox = FIM;
                    timer_prox  = '0;
                end else begin
                    timer_prox = timer + TW'(1);
                end
            end
`endif
            FIM: begin
                fim         = 1'b1;
                estado_prox = OCIOSO;
            end
            default: begin
                // Illegal codes (and PISCA when the final flash is not built)
                // report 4'b1001 and fall back to idle.
                db_estado   = 4'b1001;
                estado_prox = OCIOSO;
                timer_prox  = '0;
            end
        endcase

        // Abort wins over everything, including a start request while idle,
        // so the address and latched limit are left untouched.
        if (abortar) begin
            estado_prox   = OCIOSO;
            endereco_prox = endereco;
            limite_prox   = limite_reg;
            timer_prox    = '0;
        end
    end

endmodule

// File: tb/tb_exibe_sequencia.sv
module tb_exibe_sequencia;

    localparam int unsigned T_ON  = 4;
    localparam int unsigned T_OFF = 2;
`ifdef EXIBE_PISCA_FINAL_EN
    localparam int EXTRA = int'(T_ON);
`else
    localparam int EXTRA = 0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       abortar;
    logic [3:0] limite;
    logic [3:0] dado;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       fim;
    logic [3:0] db_estado;

    logic [3:0] mem [16];

    always #5 clock = ~clock;

    assign dado = mem[endereco];

    exibe_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .abortar   (abortar),
        .limite    (limite),
        .dado      (dado),
        .endereco  (endereco),
        .leds      (leds),
        .ocupado   (ocupado),
        .fim       (fim),
        .db_estado (db_estado)
    );

    typedef struct {
        logic [3:0] leds;
        logic       fim;
        logic       ocup;
        logic [3:0] ender;
        logic [3:0] st;
    } exp_t;

    typedef struct {
        logic [3:0] lim;
        logic [3:0] m0;
        logic [3:0] ml;
        bit         noise;
        int         exp_fim;
    } vec_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string nome, input int atual, input int esperado);
        total++;
        if (atual == esperado) passed++;
        else $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
    endtask

    task automatic push(input logic [3:0] l, input logic f, input logic o,
                        input logic [3:0] e, input logic [3:0] s);
        exp_t x;
        x.leds = l; x.fim = f; x.ocup = o; x.ender = e; x.st = s;
        q.push_back(x);
    endtask

    // Expected cycle-by-cycle trace of a run, from the cycle after the start
    // edge through the first idle cycle after fim.
    task automatic build(input logic [3:0] lim);
        q.delete();
        push(4'h0, 1'b0, 1'b1, 4'h0, 4'd1);
        for (int i = 0; i <= int'(lim); i++) begin
            for (int k = 0; k < int'(T_ON); k++)  push(mem[i], 1'b0, 1'b1, 4'(i), 4'd2);
            for (int k = 0; k < int'(T_OFF); k++) push(4'h0, 1'b0, 1'b1, 4'(i), 4'd3);
            if (i < int'(lim)) push(4'h0, 1'b0, 1'b1, 4'(i), 4'd4);
        end
`ifdef EXIBE_PISCA_FINAL_EN
        for (int k = 0; k < int'(T_ON); k++) push(4'hF, 1'b0, 1'b1, lim, 4'd5);
`endif
        push(4'h0, 1'b1, 1'b1, lim, 4'd6);
        push(4'h0, 1'b0, 1'b0, lim, 4'd0);
    endtask

    // Call right after a falling edge with the DUT idle.
    task automatic run_seq(input logic [3:0] lim, input bit noise, input int exp_fim);
        int fim_at;
        int n;
        build(lim);
        fim_at  = 0;
        n       = q.size();
        limite  = lim;
        iniciar = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clock);
            chk($sformatf("leds L%0d c%0d", lim, c), int'(leds), int'(q[c-1].leds));
            chk($sformatf("fim L%0d c%0d", lim, c), int'(fim), int'(q[c-1].fim));
            chk($sformatf("ocupado L%0d c%0d", lim, c), int'(ocupado), int'(q[c-1].ocup));
            chk($sformatf("endereco L%0d c%0d", lim, c), int'(endereco), int'(q[c-1].ender));
            chk($sformatf("db_estado L%0d c%0d", lim, c), int'(db_estado), int'(q[c-1].st));
            if (fim && fim_at == 0) fim_at = c;
            if (noise && c < n) begin
                iniciar = 1'($urandom_range(0, 1));
                limite  = 4'($urandom_range(0, 15));
            end else begin
                iniciar = 1'b0;
            end
        end
        chk($sformatf("latencia fim L%0d", lim), fim_at, exp_fim);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[5];
        int   fims;

        tab[0] = '{lim: 4'd2,  m0: 4'b0001, ml: 4'b0100, noise: 1'b0, exp_fim: 22 + EXTRA};
        tab[1] = '{lim: 4'd0,  m0: 4'b1000, ml: 4'b1000, noise: 1'b0, exp_fim: 8 + EXTRA};
        tab[2] = '{lim: 4'd15, m0: 4'b0011, ml: 4'b1111, noise: 1'b0, exp_fim: 113 + EXTRA};
        tab[3] = '{lim: 4'd1,  m0: 4'b0000, ml: 4'b0110, noise: 1'b0, exp_fim: 15 + EXTRA};
        tab[4] = '{lim: 4'd2,  m0: 4'b0001, ml: 4'b0100, noise: 1'b1, exp_fim: 22 + EXTRA};

        for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));

        reset   = 1'b0;
        iniciar = 1'b0;
        abortar = 1'b0;
        limite  = 4'd0;

        #12;
        chk("reset leds", int'(leds), 0);
        chk("reset endereco", int'(endereco), 0);
        chk("reset ocupado", int'(ocupado), 0);
        chk("reset fim", int'(fim), 0);
        chk("reset db_estado", int'(db_estado), 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Table-driven runs
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));
            mem[0]          = tab[t].m0;
            mem[tab[t].lim] = tab[t].ml;
            run_seq(tab[t].lim, tab[t].noise, tab[t].exp_fim);
        end

        // Abort during the second lit cycle of item 1
        for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));
        limite  = 4'd2;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        repeat (9) @(negedge clock);
        chk("abort pre leds", int'(leds), 4'b0010);
        chk("abort pre db_estado", int'(db_estado), 2);
        abortar = 1'b1;
        @(negedge clock);
        abortar = 1'b0;
        chk("abort db_estado", int'(db_estado), 0);
        chk("abort leds", int'(leds), 0);
        chk("abort ocupado", int'(ocupado), 0);
        chk("abort fim", int'(fim), 0);
        fims = 0;
        repeat (30) begin
            @(negedge clock);
            if (fim) fims++;
        end
        chk("abort sem fim", fims, 0);

        // Abort together with start while idle keeps the block idle
        abortar = 1'b1;
        iniciar = 1'b1;
        @(negedge clock);
        abortar = 1'b0;
        iniciar = 1'b0;
        chk("abort+iniciar db_estado", int'(db_estado), 0);
        chk("abort+iniciar ocupado", int'(ocupado), 0);
        @(negedge clock);
        chk("abort+iniciar depois", int'(db_estado), 0);

        // Reset in the dark gap of item 1, then replay from address 0
        limite  = 4'd2;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        repeat (12) @(negedge clock);
        chk("pre reset db_estado", int'(db_estado), 3);
        chk("pre reset endereco", int'(endereco), 1);
        #1 reset = 1'b0;
        #1;
        chk("reset meio leds", int'(leds), 0);
        chk("reset meio endereco", int'(endereco), 0);
        chk("reset meio ocupado", int'(ocupado), 0);
        chk("reset meio fim", int'(fim), 0);
        chk("reset meio db_estado", int'(db_estado), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("pos reset ocioso", int'(db_estado), 0);
        run_seq(4'd2, 1'b0, 22 + EXTRA);

        // Randomised runs: random lengths and contents, noisy inputs while busy
        for (int r = 0; r < 8; r++) begin
            logic [3:0] lim;
            lim = 4'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
            run_seq(lim, 1'b1,
                    1 + (int'(lim) + 1) * int'(T_ON + T_OFF) + int'(lim) + 1 + EXTRA);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
